// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO with a valid/ready push port.
// ena = 0 freezes every register so a frame resumes exactly where it paused.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_done;

    assign wr_ready = ena & (fifo_count < CNT_FULL);
    assign busy     = (state != IDLE) | (fifo_count != '0);
    assign push     = wr_valid & wr_ready;
    assign bit_done = (timer == '0);
    // A byte leaves the FIFO either from idle or right at the end of a stop bit,
    // which is what makes back-to-back frames gapless.
    assign pop      = ena & (fifo_count != '0) &
                      ((state == IDLE) | ((state == STOP) & bit_done));

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (ena) begin
            if (wr_valid && (fifo_count == CNT_FULL)) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            // Every bit boundary reloads the timer; the bit ends when it reaches zero.
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        timer <= TMR_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        timer   <= TMR_LOAD;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= TMR_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            timer <= TMR_LOAD;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: pushed bytes go to a scoreboard queue and a
// UART receiver process decodes tx, checking each frame against the queue head.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         cycle_cnt = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one push for a single edge; only pushes the DUT should accept are scored.
    task automatic applyStimulus(input logic [7:0] data, input bit accept);
        wr_data  = data;
        wr_valid = 1'b1;
        if (accept) exp_q.push_back(data);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic waitIdle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        if (busy) begin
            errors++;
            $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles", bound);
        end
    endtask

    // Receiver: advances its bit position only across edges where ena was high,
    // and drops a partly received frame when reset hits.
    initial begin : monitor
        logic       prev_ena;
        logic       prev_rst;
        logic       receiving;
        int         off;
        logic [7:0] rx;
        logic [7:0] exp;
        prev_ena  = 1'b0;
        prev_rst  = 1'b0;
        receiving = 1'b0;
        off       = 0;
        rx        = '0;
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                receiving = 1'b0;
            end else if (prev_ena) begin
                if (!receiving) begin
                    if (tx === 1'b0) begin
                        receiving = 1'b1;
                        off       = 0;
                        start_q.push_back(cycle_cnt);
                    end
                end else begin
                    off++;
                    if (off == 2) begin
                        checkOutput("start_bit", 32'(tx), 32'd0);
                    end else if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) begin
                        rx[(off - 6) / 4] = tx;
                    end else if (off == 38) begin
                        checkOutput("stop_bit", 32'(tx), 32'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", rx);
                        end else begin
                            exp = exp_q.pop_front();
                            checkOutput("rx_byte", 32'(rx), 32'(exp));
                        end
                        receiving = 1'b0;
                    end
                end
            end
            prev_ena = ena;
            prev_rst = rst_n;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst_n    = 1'b0;
        ena      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;

        // Reset with a pending write must leave an empty, idle block
        repeat (5) step();
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        step();
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single byte: start bit one edge after the push, idle 40 cycles later
        applyStimulus(8'hA5, 1'b1);
        checkOutput("single_count", 32'(fifo_count), 32'd1);
        checkOutput("single_tx_pre", 32'(tx), 32'd1);
        checkOutput("single_busy", 32'(busy), 32'd1);
        step();
        checkOutput("single_tx_start", 32'(tx), 32'd0);
        checkOutput("single_count_pop", 32'(fifo_count), 32'd0);
        waitIdle(100, n);
        checkOutput("single_duration", 32'(n), 32'd40);
        repeat (3) step();

        // Burst of four: count peaks at 3, frames are gapless, 160 cycles total
        start_q.delete();
        applyStimulus(8'h00, 1'b1);
        checkOutput("burst_count1", 32'(fifo_count), 32'd1);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("burst_count2", 32'(fifo_count), 32'd1);
        applyStimulus(8'h55, 1'b1);
        checkOutput("burst_count3", 32'(fifo_count), 32'd2);
        applyStimulus(8'h0F, 1'b1);
        checkOutput("burst_count4", 32'(fifo_count), 32'd3);
        waitIdle(300, n);
        checkOutput("burst_duration", 32'(n), 32'd158);
        repeat (3) step();
        checkOutput("burst_frames", 32'(start_q.size()), 32'd4);
        for (int i = 1; i < start_q.size(); i++) begin
            checkOutput("burst_gap", 32'(start_q[i] - start_q[i-1]), 32'd40);
        end

        // Fill the FIFO behind a running frame, then overflow it
        applyStimulus(8'h11, 1'b1);
        repeat (3) step();
        applyStimulus(8'h21, 1'b1);
        applyStimulus(8'h32, 1'b1);
        applyStimulus(8'h43, 1'b1);
        checkOutput("full_count3", 32'(fifo_count), 32'd3);
        checkOutput("full_ready3", 32'(wr_ready), 32'd1);
        applyStimulus(8'h54, 1'b1);
        checkOutput("full_count4", 32'(fifo_count), 32'd4);
        checkOutput("full_ready4", 32'(wr_ready), 32'd0);
        checkOutput("full_ovf_pre", 32'(overflow), 32'd0);
        applyStimulus(8'h65, 1'b0);
        checkOutput("full_count_hold", 32'(fifo_count), 32'd4);
        checkOutput("full_ovf_set", 32'(overflow), 32'd1);
        waitIdle(500, n);
        repeat (3) step();
        checkOutput("full_ovf_sticky", 32'(overflow), 32'd1);

        // Reset during data bit 3 aborts the frame and discards the queued byte
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h99, 1'b1);
        repeat (17) step();
        checkOutput("abort_bit3", 32'(tx), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        step();
        checkOutput("abort_tx", 32'(tx), 32'd1);
        checkOutput("abort_count", 32'(fifo_count), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();
        applyStimulus(8'h81, 1'b1);
        waitIdle(100, n);
        repeat (3) step();

        // Freeze during data bit 5 of 0xC3 for 10 cycles
        applyStimulus(8'hC3, 1'b1);
        step();
        repeat (25) step();
        checkOutput("freeze_bit5", 32'(tx), 32'd0);
        ena      = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        #1;
        checkOutput("freeze_wr_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("freeze_tx", 32'(tx), 32'd0);
            checkOutput("freeze_count", 32'(fifo_count), 32'd0);
        end
        ena      = 1'b1;
        wr_valid = 1'b0;
        step();
        checkOutput("resume_bit5a", 32'(tx), 32'd0);
        step();
        checkOutput("resume_bit5b", 32'(tx), 32'd0);
        step();
        checkOutput("resume_bit6", 32'(tx), 32'd1);
        waitIdle(100, n);
        repeat (5) step();

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
